// File: rtl/ps2_host_tx_if.sv
// Command/status bundle between the PS/2 host transmitter and its user logic,
// including the open-drain enables that the top level turns into 0/'z' on the pins.
interface ps2_host_tx_if;
  logic       start;
  logic [7:0] tx_byte;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output start,
    output tx_byte,
    input  ps2_clk_oe,
    input  ps2_dat_oe,
    input  busy,
    input  done,
    input  ack_err,
    input  timeout
  );

  modport slave (
    input  start,
    input  tx_byte,
    output ps2_clk_oe,
    output ps2_dat_oe,
    output busy,
    output done,
    output ack_err,
    output timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB-first,
// odd parity, stop, then device ack check, all under a per-edge watchdog.
module ps2_host_tx #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int START_SETUP_CYCLES = 250,
  parameter int TIMEOUT_CYCLES     = 750000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         PS2_CLK,
  input  logic         PS2_DAT,
  ps2_host_tx_if.slave bus
);

  localparam int INH_W = $clog2(CLK_INHIBIT_CYCLES) + 1;
  localparam int SET_W = $clog2(START_SETUP_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(START_SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_ACK,
    WAIT_IDLE
  } state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t           state;
  logic [9:0]       frame;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] inh_cnt;
  logic [SET_W-1:0] setup_cnt;
  logic [TO_W-1:0]  wdog;

  logic clk_oe;
  logic dat_oe;
  logic busy;
  logic done;
  logic ack_err;
  logic timeout;

  logic clk_meta_p0;
  logic clk_sync_p1;
  logic clk_prev_p2;
  logic dat_meta_p0;
  logic dat_sync_p1;
  logic fall;

  // p0 -> p1: two-flop synchronisers on the raw lines; p2 keeps the previous clock sample
  always_ff @(posedge CLOCK_50) begin
    clk_meta_p0 <= PS2_CLK;
    clk_sync_p1 <= clk_meta_p0;
    clk_prev_p2 <= clk_sync_p1;
    dat_meta_p0 <= PS2_DAT;
    dat_sync_p1 <= dat_meta_p0;
  end

  assign fall = clk_prev_p2 & ~clk_sync_p1;

  // p2 -> control: protocol state machine with registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      frame     <= '0;
      bit_idx   <= '0;
      inh_cnt   <= '0;
      setup_cnt <= '0;
      wdog      <= '0;
      clk_oe    <= 1'b0;
      dat_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          if (bus.start) begin
            frame   <= {1'b1, odd_parity(bus.tx_byte), bus.tx_byte};
            ack_err <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            clk_oe  <= 1'b1;
            inh_cnt <= '0;
            state   <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            inh_cnt   <= '0;
            setup_cnt <= '0;
            dat_oe    <= 1'b1;
            state     <= REQ;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end

        REQ: begin
          if (setup_cnt == SET_LAST) begin
            setup_cnt <= '0;
            clk_oe    <= 1'b0;
            bit_idx   <= '0;
            wdog      <= '0;
            state     <= SEND;
          end else begin
            setup_cnt <= setup_cnt + SET_W'(1);
          end
        end

        SEND: begin
          if (wdog == TO_LAST) begin
            clk_oe  <= 1'b0;
            dat_oe  <= 1'b0;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            bit_idx <= '0;
            state   <= IDLE;
          end else if (fall) begin
            wdog   <= '0;
            // Stop bit is a 1 in the frame, so this also releases the data line
            dat_oe <= ~frame[bit_idx];
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              state   <= WAIT_ACK;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            wdog <= wdog + TO_W'(1);
          end
        end

        WAIT_ACK: begin
          if (wdog == TO_LAST) begin
            clk_oe  <= 1'b0;
            dat_oe  <= 1'b0;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (fall) begin
            ack_err <= dat_sync_p1;
            wdog    <= '0;
            state   <= WAIT_IDLE;
          end else begin
            wdog <= wdog + TO_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (wdog == TO_LAST) begin
            clk_oe  <= 1'b0;
            dat_oe  <= 1'b0;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (clk_sync_p1 && dat_sync_p1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wdog <= wdog + TO_W'(1);
          end
        end

        default: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ps2_clk_oe = clk_oe;
  assign bus.ps2_dat_oe = dat_oe;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.ack_err    = ack_err;
  assign bus.timeout    = timeout;

endmodule
